// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector with Mealy match flag,
// registered copy of the flag and a saturating match counter.
module seq_detector_param #(
  parameter int                 SEQ_LEN = 4,
  parameter logic [SEQ_LEN-1:0] PATTERN = 4'b1101,
  parameter int                 CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in,
  input  logic             in_valid,
  input  logic             overlap,
  input  logic             clear,
  output logic             out,
  output logic             out_q,
  output logic [CNT_W-1:0] match_count
);

  localparam int FW = $clog2(SEQ_LEN);
  localparam logic [FW-1:0] FULL = FW'(SEQ_LEN - 1);

  logic [SEQ_LEN-2:0] hist;
  logic [SEQ_LEN-2:0] hist_n;
  logic [FW-1:0]      fill;
  logic [FW-1:0]      fill_n;
  logic [CNT_W-1:0]   cnt_n;
  logic               out_q_n;
  logic [SEQ_LEN-1:0] win;

  assign win = {hist, in};

  always_comb begin
    out = ~reset & ~clear & in_valid
        & (fill == FULL) & (win == PATTERN);
  end

  always_comb begin
    hist_n  = hist;
    fill_n  = fill;
    cnt_n   = match_count;
    out_q_n = out;
    if (clear) begin
      hist_n  = '0;
      fill_n  = '0;
      cnt_n   = '0;
      out_q_n = 1'b0;
    end else if (in_valid) begin
      // non-overlapping mode restarts from an empty window
      if (out && !overlap) begin
        fill_n = '0;
      end else begin
        hist_n = win[SEQ_LEN-2:0];
        if (fill != FULL)
          fill_n = fill + 1'b1;
      end
      if (out && match_count != '1)
        cnt_n = match_count + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hist        <= '0;
      fill        <= '0;
      match_count <= '0;
      out_q       <= 1'b0;
    end else begin
      hist        <= hist_n;
      fill        <= fill_n;
      match_count <= cnt_n;
      out_q       <= out_q_n;
    end
  end

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: three configurations driven by one
// stream, each compared against a queue-based pattern model.
module tb_seq_detector_param;

  logic clk = 1'b0;
  logic reset, in, in_valid, overlap, clear;

  logic       o   [3];
  logic       oq  [3];
  logic [7:0] c0;
  logic [2:0] c1;
  logic [7:0] c2;

  int len  [3] = '{4, 2, 5};
  int pat  [3] = '{13, 3, 21};
  int maxc [3] = '{255, 7, 255};

  bit q    [3][$];
  int mcnt [3];
  int moq  [3];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  seq_detector_param #(.SEQ_LEN(4), .PATTERN(4'b1101), .CNT_W(8)) u0 (
    .clk(clk), .reset(reset), .in(in), .in_valid(in_valid),
    .overlap(overlap), .clear(clear),
    .out(o[0]), .out_q(oq[0]), .match_count(c0));

  seq_detector_param #(.SEQ_LEN(2), .PATTERN(2'b11), .CNT_W(3)) u1 (
    .clk(clk), .reset(reset), .in(in), .in_valid(in_valid),
    .overlap(overlap), .clear(clear),
    .out(o[1]), .out_q(oq[1]), .match_count(c1));

  seq_detector_param #(.SEQ_LEN(5), .PATTERN(5'b10101), .CNT_W(8)) u2 (
    .clk(clk), .reset(reset), .in(in), .in_valid(in_valid),
    .overlap(overlap), .clear(clear),
    .out(o[2]), .out_q(oq[2]), .match_count(c2));

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_match(input int i);
    int L;
    L = len[i];
    if (reset || clear || !in_valid) return 1'b0;
    if (q[i].size() != L - 1) return 1'b0;
    for (int k = 0; k < L - 1; k++)
      if (q[i][k] != pat[i][L-1-k]) return 1'b0;
    return in == pat[i][0];
  endfunction

  function automatic int dut_cnt(input int i);
    case (i)
      0: return int'(c0);
      1: return int'(c1);
      default: return int'(c2);
    endcase
  endfunction

  task automatic step(input bit r, input bit c, input bit v,
                      input bit b, input bit ov, input string tag);
    bit m [3];
    reset = r; clear = c; in_valid = v; in = b; overlap = ov;
    #3;
    for (int i = 0; i < 3; i++) begin
      m[i] = model_match(i);
      chk($sformatf("%s out[%0d]", tag, i), int'(o[i]), int'(m[i]));
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      if (r || c) begin
        q[i].delete();
        mcnt[i] = 0;
        moq[i] = 0;
      end else if (!v) begin
        moq[i] = 0;
      end else begin
        moq[i] = int'(m[i]);
        if (m[i] && mcnt[i] < maxc[i]) mcnt[i]++;
        if (m[i] && !ov) begin
          q[i].delete();
        end else begin
          q[i].push_back(b);
          if (q[i].size() > len[i] - 1) void'(q[i].pop_front());
        end
      end
      chk($sformatf("%s out_q[%0d]", tag, i), int'(oq[i]), moq[i]);
      chk($sformatf("%s cnt[%0d]", tag, i), dut_cnt(i), mcnt[i]);
    end
  endtask

  task automatic stream(input string tag, input bit ov,
                        input int n, input bit [15:0] bits);
    for (int k = n - 1; k >= 0; k--)
      step(0, 0, 1, bits[k], ov, tag);
  endtask

  initial begin
    reset = 1; clear = 0; in_valid = 0; in = 0; overlap = 0;
    for (int i = 0; i < 3; i++) begin mcnt[i] = 0; moq[i] = 0; end
    @(posedge clk); #1;
    step(1, 0, 0, 0, 0, "rst");
    step(1, 0, 1, 1, 0, "rst");
    chk("reset cnt0", int'(c0), 0);

    stream("nonovl", 0, 9, 16'b110110101);
    chk("nonovl final cnt0", int'(c0), 1);
    step(1, 0, 0, 0, 0, "rst");
    stream("ovl", 1, 9, 16'b110110101);
    chk("ovl final cnt0", int'(c0), 2);

    step(1, 0, 0, 0, 0, "rst");
    stream("gap", 1, 2, 16'b11);
    for (int k = 0; k < 3; k++) step(0, 0, 0, k[0], 1, "gap idle");
    stream("gap", 1, 2, 16'b01);
    chk("gap final cnt0", int'(c0), 1);

    step(1, 0, 0, 0, 0, "rst");
    stream("sat", 1, 12, 16'hfff);
    chk("sat cnt1", int'(c1), 7);

    step(1, 0, 0, 0, 0, "rst");
    stream("partial", 0, 3, 16'b110);
    step(1, 0, 1, 1, 0, "partial rst");
    stream("partial", 0, 1, 16'b1);
    stream("partial", 0, 3, 16'b110);
    step(0, 1, 1, 1, 0, "partial clr");
    stream("partial", 0, 1, 16'b1);
    chk("clear cnt0", int'(c0), 0);

    step(1, 0, 0, 0, 0, "rst");
    stream("p5ovl", 1, 7, 16'b1010101);
    chk("p5ovl cnt2", int'(c2), 2);
    step(1, 0, 0, 0, 0, "rst");
    stream("p5nov", 0, 7, 16'b1010101);
    chk("p5nov cnt2", int'(c2), 1);

    for (int t = 0; t < 3000; t++) begin
      bit r, c, v, b, ov;
      r  = ($urandom_range(0, 199) == 0);
      c  = ($urandom_range(0, 149) == 0);
      v  = ($urandom_range(0, 9) < 8);
      b  = ($urandom_range(0, 2) != 0);
      ov = ($urandom_range(0, 1) != 0);
      step(r, c, v, b, ov, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
Parametrised serial bit-pattern detector that generalises the fixed 1101 Mealy detector.
- Pattern, pattern length, overlap mode and counter width are configurable.
- Adds input qualification, a registered copy of the match output, and a saturating match counter.
- Sits on a serial input stream; drives match flags and a statistics count to downstream control logic.

Parameters:
SEQ_LEN, 4, pattern length in bits; legal range 2..16.
PATTERN, 4'b1101, SEQ_LEN-bit target pattern; MSB is the first bit received.
CNT_W, 8, width of match_count.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
in  input  1  serial data bit
in_valid  input  1  qualifies in; when low the detector holds all state
overlap  input  1  1 = overlapping detection, 0 = non-overlapping; sampled every cycle
clear  input  1  synchronous clear of history and counter; lower priority than reset
out  output  1  Mealy match flag (combinational from in, in_valid and state)
out_q  output  1  out registered one cycle later
match_count  output  CNT_W  saturating count of matches

Behaviour:
Internal state:
- hist[SEQ_LEN-2:0]: last SEQ_LEN-1 accepted bits, most recent bit in bit 0.
- fill: 0..SEQ_LEN-1, number of accepted bits currently usable in hist.

Mealy output:
- out = in_valid & (fill == SEQ_LEN-1) & ({hist,in} == PATTERN).
- out is never asserted while reset or clear is high.

Reset (reset=1 at a posedge):
- hist=0, fill=0, out_q=0, match_count=0.
- out is forced to 0 while reset is high.
- Reset mid-sequence discards any partial match.

Clear (clear=1, reset=0):
- Same effect as reset on hist, fill, out_q and match_count.
- The bit presented in that cycle is discarded.

Normal cycle (reset=0, clear=0):
- in_valid=0: hist, fill and match_count hold; out_q<=0.
- in_valid=1 and out=1 and overlap=0: fill<=0, so the next match needs SEQ_LEN fresh bits.
- in_valid=1 otherwise: hist<={hist[SEQ_LEN-3:0],in}; fill<=min(fill+1, SEQ_LEN-1).
- out_q<=out.
- match_count<=match_count+1 when out=1, unless it is already 2^CNT_W-1 (saturates, no wrap).

Mode and latency:
- A change of overlap applies to the match decision in the same cycle it is presented; no history is lost.
- Latency: out is asserted in the same cycle as the final pattern bit; out_q and the updated match_count appear at the next posedge.
- Bits with in_valid low are invisible: a pattern may be split across gaps in in_valid.

Test Plan:
1. Reset for 2 cycles, then overlap=0, in_valid=1, stream 1,1,0,1,1,0,1,0,1 -> out high only on bit 4 (index 3); match_count=1 at end; out_q high one cycle after out.
2. Same stream with overlap=1 -> out high on bits 4 and 7; match_count=2.
3. overlap=1, stream 1,1,0,1 with in_valid=0 for 3 cycles between bits 2 and 3 -> out high on bit 4 only; state holds through the gap; match_count=1.
4. CNT_W=3, overlap=1, SEQ_LEN=2, PATTERN=2'b11, stream of 12 ones -> out high on bits 2..12; match_count saturates at 7 and stays there.
5. overlap=0, stream 1,1,0, then reset=1 for 1 cycle, then 1 -> out stays 0 (partial match discarded); fill=1 after the final bit. Repeat with clear instead of reset -> identical result, and match_count=0.
6. SEQ_LEN=5, PATTERN=5'b10101, overlap=1, stream 1,0,1,0,1,0,1 -> out on bits 5 and 7; with overlap=0 -> out on bit 5 only.
